// File: rtl/conv_pkg.sv
// Shared types and constants for the conv10 multiply-accumulate lanes.
// sat_add is used by conv_mac_unit only when CONV_MAC_SAT_EN is defined.
package conv_pkg;

   localparam int WIDTH = 16;
   localparam int ACC_W = 2 * WIDTH;

   typedef logic signed [WIDTH-1:0] pix_t;
   typedef logic signed [WIDTH-1:0] ker_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Overflow only happens when both operands share a sign that the raw sum loses.
   function automatic acc_t sat_add(input acc_t a, input acc_t b, output logic overflow);
      acc_t sum;
      sum      = a + b;
      overflow = (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
      if (overflow) begin
         return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end
      return sum;
   endfunction

endpackage

// File: rtl/conv_mac_unit_if.sv
// Operand/result bundle between the convolution array controller and one MAC lane.
interface conv_mac_unit_if;
   import conv_pkg::*;

   logic clr;
   logic layer_en;
   pix_t pix;
   ker_t ker;
   acc_t mul_out;
   logic ovf;

   modport master (
      output clr,
      output layer_en,
      output pix,
      output ker,
      input  mul_out,
      input  ovf
   );

   modport slave (
      input  clr,
      input  layer_en,
      input  pix,
      input  ker,
      output mul_out,
      output ovf
   );

endinterface

// File: rtl/conv_mac_mult.sv
// Combinational signed WIDTH x WIDTH -> ACC_W product, isolated so it maps onto a DSP slice.
module conv_mac_mult
   import conv_pkg::*;
(
   input  pix_t pix,
   input  ker_t ker,
   output acc_t prod
);

   assign prod = acc_t'(pix) * acc_t'(ker);

endmodule

// File: rtl/conv_mac_unit.sv
// Signed MAC lane: accumulates pix*ker, cleared by clr, with a sticky overflow flag.
// Define CONV_MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module conv_mac_unit
   import conv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   conv_mac_unit_if.slave  mac
);

   acc_t prod;
   acc_t acc_q;
   acc_t acc_next;
   logic ovf_q;
   logic ovf_step;

   conv_mac_mult u_mult (
      .pix  (mac.pix),
      .ker  (mac.ker),
      .prod (prod)
   );

`ifdef CONV_MAC_SAT_EN
   always_comb begin
      ovf_step = 1'b0;
      acc_next = sat_add(acc_q, prod, ovf_step);
   end
`else
   always_comb begin
      acc_next = acc_q + prod;
      ovf_step = (acc_q[ACC_W-1] == prod[ACC_W-1]) && (acc_next[ACC_W-1] != acc_q[ACC_W-1]);
   end
`endif

   // clr wins over layer_en so operands presented alongside clr are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (mac.clr) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (mac.layer_en) begin
         acc_q <= acc_next;
         ovf_q <= ovf_q | ovf_step;
      end
   end

   assign mac.mul_out = acc_q;
   assign mac.ovf     = ovf_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Bench for conv_mac_unit: directed vector table followed by randomized traffic against a wide-integer model.
module tb_conv_mac_unit;
   import conv_pkg::*;

   typedef struct {
      logic        rst;
      logic        clr;
      logic        en;
      logic [15:0] pix;
      logic [15:0] ker;
      logic [31:0] acc;
      logic        ovf;
      logic        pre;
      logic [31:0] pre_acc;
      string       name;
   } vec_t;

   logic clk;
   logic rst;
   conv_mac_unit_if mac_if ();

   conv_mac_unit dut (
      .clk (clk),
      .rst (rst),
      .mac (mac_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   int   m_acc;
   logic m_ovf;

`ifdef CONV_MAC_SAT_EN
   localparam logic [31:0] OVF_POS_A = 32'h7FFF_FFFF;
   localparam logic [31:0] OVF_POS_B = 32'h7FFF_FFFF;
   localparam logic [31:0] OVF_NEG   = 32'h8000_0000;
`else
   localparam logic [31:0] OVF_POS_A = 32'hBFFE_0001;
   localparam logic [31:0] OVF_POS_B = 32'h8000_0000;
   localparam logic [31:0] OVF_NEG   = 32'h4001_8000;
`endif

   task automatic add_vec(input logic r, input logic c, input logic e, input logic [15:0] p,
                          input logic [15:0] k, input logic [31:0] a, input logic o, input string n);
      vec_t v;
      v.rst = r; v.clr = c; v.en = e; v.pix = p; v.ker = k;
      v.acc = a; v.ovf = o; v.pre = 1'b0; v.pre_acc = '0; v.name = n;
      vecs.push_back(v);
   endtask

   // Reference: exact integer sum, flagged and wrapped/clamped when it leaves the 32-bit range.
   task automatic model_step(input logic r, input logic c, input logic e,
                             input logic [15:0] p, input logic [15:0] k);
      longint s;
      logic [63:0] s_bits;
      if (r || c) begin
         m_acc = 0;
         m_ovf = 1'b0;
      end else if (e) begin
         s = longint'(m_acc) + longint'(signed'(p)) * longint'(signed'(k));
         if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
            m_ovf = 1'b1;
`ifdef CONV_MAC_SAT_EN
            s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
         end
         s_bits = s;
         m_acc  = int'(s_bits[31:0]);
      end
   endtask

   task automatic check(input string n, input logic [31:0] got_acc, input logic [31:0] exp_acc,
                        input logic got_ovf, input logic exp_ovf);
      checks++;
      if (got_acc !== exp_acc || got_ovf !== exp_ovf) begin
         errors++;
         $display("FAIL %s: mul_out=%h ovf=%b, expected mul_out=%h ovf=%b",
                  n, got_acc, got_ovf, exp_acc, exp_ovf);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic e,
                        input logic [15:0] p, input logic [15:0] k);
      rst             = r;
      mac_if.clr      = c;
      mac_if.layer_en = e;
      mac_if.pix      = p;
      mac_if.ker      = k;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b1, 16'd5, 16'd7);
      m_acc = 0;
      m_ovf = 1'b0;

      add_vec(1, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold0");
      add_vec(1, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold1");
      add_vec(1, 0, 1, 16'd5, 16'd7, 32'd0, 0, "reset_hold2");
      add_vec(0, 0, 1, 16'd5, 16'd7, 32'd35, 0, "reset_release");
      add_vec(0, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr_start");
      add_vec(0, 0, 1, 16'd1, 16'd2, 32'd2, 0, "dot0");
      add_vec(0, 0, 1, 16'hFFFD, 16'd4, 32'hFFFF_FFF6, 0, "dot1");
      add_vec(0, 0, 1, 16'd100, 16'hFFFF, 32'hFFFF_FF92, 0, "dot2");
      add_vec(0, 0, 1, 16'h7FFF, 16'd1, 32'd32657, 0, "dot3");
      add_vec(0, 1, 1, 16'd9, 16'd9, 32'd0, 0, "sample_clr");
      vecs[$].pre = 1'b1;
      vecs[$].pre_acc = 32'd32657;
      add_vec(0, 0, 1, 16'd3, 16'd3, 32'd9, 0, "acc_after_clr");
      for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 16'd9, 16'd9, 32'd9, 0, "en_gate");
      add_vec(0, 0, 1, 16'd1, 16'd1, 32'd10, 0, "en_resume");
      add_vec(1, 1, 1, 16'd4, 16'd4, 32'd0, 0, "rst_clr_prio");
      add_vec(0, 1, 1, 16'd4, 16'd4, 32'd0, 0, "clr_b2b0");
      add_vec(0, 1, 1, 16'd4, 16'd4, 32'd0, 0, "clr_b2b1");
      add_vec(0, 0, 1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 0, "load0");
      add_vec(0, 0, 1, 16'h7FFF, 16'h7FFF, 32'h7FFE_0002, 0, "load1");
      add_vec(0, 0, 1, 16'h7FFF, 16'd2, 32'h7FFF_0000, 0, "load2");
      add_vec(0, 0, 1, 16'h7FFF, 16'h7FFF, OVF_POS_A, 1, "pos_overflow");
      add_vec(0, 0, 0, 16'd1, 16'd1, OVF_POS_A, 1, "ovf_hold");
      add_vec(0, 1, 0, 16'd0, 16'd0, 32'd0, 0, "ovf_clr");
      add_vec(0, 0, 1, 16'h8000, 16'h8000, 32'h4000_0000, 0, "corner_min_sq");
      add_vec(0, 0, 1, 16'h8000, 16'h8000, OVF_POS_B, 1, "corner_min_sq_twice");
      add_vec(0, 1, 0, 16'd0, 16'd0, 32'd0, 0, "clr_neg");
      add_vec(0, 0, 1, 16'h8000, 16'h7FFF, 32'hC000_8000, 0, "neg0");
      add_vec(0, 0, 1, 16'h8000, 16'h7FFF, 32'h8001_0000, 0, "neg1");
      add_vec(0, 0, 1, 16'h8000, 16'h7FFF, OVF_NEG, 1, "neg_overflow");
      add_vec(0, 0, 1, 16'd0, 16'd0, OVF_NEG, 1, "ovf_sticky");

      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].pix, vecs[i].ker);
         if (vecs[i].pre) begin
            checks++;
            if (mac_if.mul_out !== vecs[i].pre_acc) begin
               errors++;
               $display("FAIL %s_pre: mul_out=%h, expected %h", vecs[i].name, mac_if.mul_out, vecs[i].pre_acc);
            end
         end
         model_step(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].pix, vecs[i].ker);
         @(posedge clk);
         #1;
         check(vecs[i].name, mac_if.mul_out, vecs[i].acc, mac_if.ovf, vecs[i].ovf);
      end

      for (int n = 0; n < 400; n++) begin
         logic r, c, e;
         logic [15:0] p, k;
         r = ($urandom_range(0, 59) == 0);
         c = ($urandom_range(0, 11) == 0);
         e = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: p = 16'h7FFF;
            1: p = 16'h8000;
            default: p = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: k = 16'h7FFF;
            1: k = 16'h8000;
            default: k = 16'($urandom);
         endcase
         drive(r, c, e, p, k);
         model_step(r, c, e, p, k);
         @(posedge clk);
         #1;
         check("random", mac_if.mul_out, m_acc, mac_if.ovf, m_ovf);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_mac_unit.md
Name: conv_mac_unit

Overview:
- Signed multiply-accumulate lane used in the CHOUT-wide 1x1 convolution array of the conv10 layers.
- Each cycle it multiplies one 16-bit feature-map pixel by one 16-bit kernel weight and accumulates into a 32-bit running sum.
- The parent samples the sum (plus bias) when it pulses clr at the end of each CHIN-long dot product.
- Many instances share pix and clr; each instance gets its own ker.

Parameters:
- WIDTH, 16, bit width of pix and ker (two's complement fixed point).
- ACC_W, 2*WIDTH, accumulator and mul_out width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- clr  input  1  accumulator clear; one-cycle pulse between dot products
- layer_en  input  1  accumulate enable
- pix  input  WIDTH  signed input-feature-map sample
- ker  input  WIDTH  signed kernel weight
- mul_out  output  ACC_W  registered signed accumulator value
- ovf  output  1  sticky overflow flag since the last clr or rst

Behaviour:
- Product: prod = signed(pix) * signed(ker), full ACC_W bits, exact (no rounding).
- All state updates on the rising edge of clk, with priority rst > clr > layer_en:
  - rst=1: acc <= 0, ovf <= 0.
  - else clr=1: acc <= 0, ovf <= 0. Any pix/ker presented in that cycle is discarded, even if layer_en=1.
  - else layer_en=1: acc <= acc + prod; ovf <= ovf | overflow, where overflow means acc and prod have the same sign and the ACC_W result has the opposite sign.
  - else: acc and ovf hold.
- mul_out = acc, driven directly from the register.
  - Latency: an operand pair accepted at edge N is reflected in mul_out after edge N.
  - While clr is high, mul_out still shows the complete sum, so the parent can sample mul_out in the same cycle it asserts clr.
- Default (no macro): accumulation wraps modulo 2^ACC_W.
- Boundary cases:
  - pix = ker = -32768 gives prod = +2^30, representable, no overflow.
  - Back-to-back clr pulses keep acc at 0.
  - layer_en deasserted mid-accumulation freezes acc; accumulation resumes when layer_en returns.
  - rst mid-accumulation clears acc regardless of clr or layer_en.
- No X propagation after the first rst. Output values are 0 at reset.

Optional Feature:
- Macro: CONV_MAC_SAT_EN.
- Defined: on overflow the accumulator saturates instead of wrapping.
  - Positive overflow: acc <= 2^(ACC_W-1)-1 (0x7FFF_FFFF).
  - Negative overflow: acc <= -2^(ACC_W-1) (0x8000_0000).
  - ovf is set exactly as in the default build.
- Undefined: two's-complement wrap; ovf still reports wraps.

Decomposition:
- Shared package conv_pkg holds:
  - WIDTH and ACC_W constants;
  - typedefs pix_t, ker_t (signed WIDTH) and acc_t (signed ACC_W);
  - a function sat_add(acc_t a, acc_t b, output overflow) used when CONV_MAC_SAT_EN is defined.
- One natural sub-module: conv_mac_mult, a purely combinational signed WIDTH x WIDTH -> ACC_W multiplier, kept separate so synthesis can map it to a DSP slice.
- The accumulator, control priority and ovf logic stay in conv_mac_unit.

Test Plan:
- Reset: hold rst=1 with layer_en=1, pix=5, ker=7 for 3 cycles -> mul_out=0, ovf=0. Release rst, next edge -> mul_out=35.
- Dot product: clr pulse, then 4 cycles with layer_en=1 and (pix,ker) = (1,2), (-3,4), (100,-1), (0x7FFF,1) -> mul_out = 2, -10, -110, 32657.
- Sample/clear: in the cycle clr=1, mul_out still reads 32657. After that edge mul_out=0; the pix/ker presented with clr are not accumulated.
- Enable gating: layer_en=0 for 5 cycles with pix=ker=9 -> mul_out unchanged. Priority: rst=1 and clr=1 together -> 0.
- Overflow: load 0x7FFF_0000, then add 0x7FFF*0x7FFF -> default build gives the wrapped negative value with ovf=1. CONV_MAC_SAT_EN build gives 0x7FFF_FFFF with ovf=1. The next clr sets ovf=0.
- Corner product: pix = ker = -32768 once after clr -> mul_out = 0x4000_0000, ovf=0.
